// File: rtl/cnt163_chain.sv
// cnt163_chain: chain of SLICES 4-bit 163-style counter slices with
// synchronous clear, a two-state parallel-load handshake, combinational
// per-slice ripple carries and a registered terminal-count event stream
// with a saturating wrap counter.
module cnt163_chain #(
  parameter int SLICES = 4,
  parameter int WRAP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_n,
  input  logic                  enp,
  input  logic                  ent,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*SLICES-1:0]   load_data,
  output logic [4*SLICES-1:0]   q,
  output logic [SLICES-1:0]     slice_rco,
  output logic                  rco,
  output logic                  tc_pulse,
  output logic [WRAP_W-1:0]     wrap_cnt
);

  localparam int W = 4 * SLICES;

  typedef enum logic {RUN, APPLY} state_t;

  state_t         state;
  logic [W-1:0]   stg;
  logic [W-1:0]   q_cnt;
  logic           accept;
  logic           count_en;
  logic           wrap;

  assign load_ready = (state == RUN);
  assign accept     = load_valid & load_ready;
  // Counting is suppressed on the accept edge so the loaded value is not
  // preceded by a stray increment or wrap event.
  assign count_en   = (state == RUN) & clr_n & ~accept & enp & ent;
  assign wrap       = count_en & rco;
  assign rco        = slice_rco[SLICES-1];

  // Cascaded slice carries, gated by ent, combinational from q only.
  always_comb begin
    logic carry;
    carry     = ent;
    slice_rco = '0;
    for (int unsigned k = 0; k < SLICES; k++) begin
      carry        = carry & (q[4*k +: 4] == 4'hF);
      slice_rco[k] = carry;
    end
  end

  // Next count value: slice 0 steps on count_en, higher slices on the
  // carry out of the slice below; each slice wraps F->0 on its own.
  always_comb begin
    q_cnt = q;
    for (int unsigned k = 0; k < SLICES; k++) begin
      if (count_en && ((k == 0) || slice_rco[(k == 0) ? 0 : k-1])) begin
        q_cnt[4*k +: 4] = q[4*k +: 4] + 4'd1;
      end
    end
  end

  // Handshake FSM, staging register and counter value with clear > apply > count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      stg   <= '0;
      q     <= '0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            stg   <= load_data;
            state <= APPLY;
          end
          q <= clr_n ? q_cnt : '0;
        end
        APPLY: begin
          state <= RUN;
          q     <= clr_n ? stg : '0;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Registered wrap event and saturating wrap counter (cleared by rst_n only).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_pulse <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      tc_pulse <= wrap;
      if (wrap && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnt163_chain.sv
// Directed self-checking bench for cnt163_chain (SLICES=4); a second
// instance with WRAP_W=2 shares the stimulus to exercise saturation.
module tb_cnt163_chain;

  logic        clk;
  logic        rst_n;
  logic        clr_n;
  logic        enp;
  logic        ent;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready, load_ready2;
  logic [15:0] q, q2;
  logic [3:0]  slice_rco, slice_rco2;
  logic        rco, rco2;
  logic        tc_pulse, tc_pulse2;
  logic [7:0]  wrap_cnt;
  logic [1:0]  wrap_cnt2;

  int checks   = 0;
  int failures = 0;

  cnt163_chain #(.SLICES(4), .WRAP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .enp(enp), .ent(ent),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .q(q), .slice_rco(slice_rco), .rco(rco), .tc_pulse(tc_pulse),
    .wrap_cnt(wrap_cnt)
  );

  cnt163_chain #(.SLICES(4), .WRAP_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .enp(enp), .ent(ent),
    .load_valid(load_valid), .load_ready(load_ready2), .load_data(load_data),
    .q(q2), .slice_rco(slice_rco2), .rco(rco2), .tc_pulse(tc_pulse2),
    .wrap_cnt(wrap_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a load with counting disabled, then let APPLY write it.
  task automatic do_load(input logic [15:0] d);
    enp        = 1'b0;
    ent        = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    step();
    chk("load_accept_ready", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    step();
    chk("load_apply_q", {16'd0, q}, {16'd0, d});
    chk("load_apply_ready", {31'd0, load_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; clr_n = 1'b1; enp = 1'b0; ent = 1'b0;
    load_valid = 1'b0; load_data = '0;
    #12;
    chk("rst_q", {16'd0, q}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_tc", {31'd0, tc_pulse}, 32'd0);
    chk("rst_wrap", {24'd0, wrap_cnt}, 32'd0);
    chk("rst_slice_rco", {28'd0, slice_rco}, 32'd0);
    chk("rst_rco", {31'd0, rco}, 32'd0);
    rst_n = 1'b1;

    // Basic count 1..20
    enp = 1'b1; ent = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("count_q", {16'd0, q}, i);
      chk("count_ready", {31'd0, load_ready}, 32'd1);
      chk("count_tc", {31'd0, tc_pulse}, 32'd0);
    end

    // Slice carry 00FF -> 0100
    do_load(16'h00FF);
    ent = 1'b1;
    #1;
    chk("carry_slice_rco", {28'd0, slice_rco}, 32'h3);
    chk("carry_rco", {31'd0, rco}, 32'd0);
    enp = 1'b1;
    step();
    chk("carry_q", {16'd0, q}, 32'h0100);

    // Wrap FFFE -> FFFF -> 0000 -> 0001
    do_load(16'hFFFE);
    enp = 1'b1; ent = 1'b1;
    #1;
    chk("wrap_rco_fffe", {31'd0, rco}, 32'd0);
    step();
    chk("wrap_q_ffff", {16'd0, q}, 32'hFFFF);
    chk("wrap_rco_ffff", {31'd0, rco}, 32'd1);
    chk("wrap_tc_ffff", {31'd0, tc_pulse}, 32'd0);
    step();
    chk("wrap_q_0", {16'd0, q}, 32'h0000);
    chk("wrap_rco_0", {31'd0, rco}, 32'd0);
    chk("wrap_tc_0", {31'd0, tc_pulse}, 32'd1);
    chk("wrap_cnt_1", {24'd0, wrap_cnt}, 32'd1);
    step();
    chk("wrap_q_1", {16'd0, q}, 32'h0001);
    chk("wrap_tc_1", {31'd0, tc_pulse}, 32'd0);
    chk("wrap_sat_1", {30'd0, wrap_cnt2}, 32'd1);

    // Enable gating
    do_load(16'h000F);
    ent = 1'b1; enp = 1'b0;
    #1;
    chk("gate_slice_rco_ent", {28'd0, slice_rco}, 32'h1);
    step();
    chk("gate_q_enp0", {16'd0, q}, 32'h000F);
    ent = 1'b0;
    #1;
    chk("gate_slice_rco_ent0", {28'd0, slice_rco}, 32'h0);
    enp = 1'b1;
    step();
    chk("gate_q_ent0", {16'd0, q}, 32'h000F);
    enp = 1'b0;

    // Back-to-back loads with load_valid held high
    load_valid = 1'b1; load_data = 16'h1234;
    chk("hs_ready_pre", {31'd0, load_ready}, 32'd1);
    step();
    chk("hs_ready_a1", {31'd0, load_ready}, 32'd0);
    chk("hs_q_a1", {16'd0, q}, 32'h000F);
    enp = 1'b1; ent = 1'b1;
    step();
    chk("hs_ready_p1", {31'd0, load_ready}, 32'd1);
    chk("hs_q_p1", {16'd0, q}, 32'h1234);
    enp = 1'b0; ent = 1'b0;
    step();
    chk("hs_ready_a2", {31'd0, load_ready}, 32'd0);
    enp = 1'b1; ent = 1'b1;
    step();
    chk("hs_ready_p2", {31'd0, load_ready}, 32'd1);
    chk("hs_q_p2", {16'd0, q}, 32'h1234);
    load_valid = 1'b0; enp = 1'b0; ent = 1'b0;

    // Clear during APPLY aborts the load
    load_valid = 1'b1; load_data = 16'hABCD;
    step();
    chk("clr_accept_ready", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0; clr_n = 1'b0;
    step();
    chk("clr_apply_q", {16'd0, q}, 32'd0);
    chk("clr_apply_ready", {31'd0, load_ready}, 32'd1);
    chk("clr_apply_tc", {31'd0, tc_pulse}, 32'd0);
    clr_n = 1'b1;
    step();
    chk("clr_after_q", {16'd0, q}, 32'd0);

    // Four more wraps: 5 total
    for (int i = 0; i < 4; i++) begin
      do_load(16'hFFFF);
      enp = 1'b1; ent = 1'b1;
      step();
      chk("sat_wrap_q", {16'd0, q}, 32'd0);
      chk("sat_wrap_tc", {31'd0, tc_pulse}, 32'd1);
    end
    enp = 1'b0; ent = 1'b0;
    chk("sat_wrap_cnt8", {24'd0, wrap_cnt}, 32'd5);
    chk("sat_wrap_cnt2", {30'd0, wrap_cnt2}, 32'd3);
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    chk("sat_clr_wrap2", {30'd0, wrap_cnt2}, 32'd3);
    chk("sat_clr_wrap8", {24'd0, wrap_cnt}, 32'd5);

    // Asynchronous reset in the middle of APPLY
    do_load(16'h0042);
    load_valid = 1'b1; load_data = 16'h7777;
    step();
    chk("arst_apply_ready", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", {16'd0, q}, 32'd0);
    chk("arst_ready", {31'd0, load_ready}, 32'd1);
    chk("arst_tc", {31'd0, tc_pulse}, 32'd0);
    chk("arst_wrap8", {24'd0, wrap_cnt}, 32'd0);
    chk("arst_wrap2", {30'd0, wrap_cnt2}, 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("arst_after_q", {16'd0, q}, 32'd0);
    chk("arst_after_ready", {31'd0, load_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
